csr_diff_buffer: RTL and testbench

CSR_DIFF_BUFFER -- requirements
Module: csr_diff_buffer

---
 rtl/csr_diff_buffer.sv | 143 ++++++++++++++
 tb/tb_csr_diff_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_diff_buffer.sv
// csr_diff_buffer
// Captures CSR snapshots at commit time into a small FIFO. In delta mode a
// commit whose CSRs and privilege match the last enqueued entry is filtered,
// and each stored entry carries a per-slot "changed" mask. Commits that
// arrive while the FIFO is full are dropped and counted. The shadow copy is
// left untouched on a drop, so the next delta spans all skipped changes.
module csr_diff_buffer #(
  parameter int NCSR  = 17,
  parameter int XLEN  = 76,
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        mode,
  input  logic                        commit_valid,
  input  logic [1:0]                  commit_priv,
  input  logic [NCSR*XLEN-1:0]        commit_csrs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_priv,
  output logic [NCSR*XLEN-1:0]        out_csrs,
  output logic [NCSR-1:0]             out_mask,
  output logic [15:0]                 out_seq,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VW = NCSR * XLEN;
  // Entry layout: {priv, csrs, mask, seq}
  localparam int EW = 2 + VW + NCSR + 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO storage and pointers
  logic [EW-1:0]   entry_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;

  // Shadow of the last enqueued commit
  logic            shadow_valid_reg;
  logic [1:0]      shadow_priv_reg;
  logic [VW-1:0]   shadow_csrs_reg;

  logic [15:0]     seq_reg;
  logic            overflow_reg;
  logic [15:0]     drop_cnt_reg;

  logic [NCSR-1:0] diff_mask;
  logic [NCSR-1:0] commit_mask;
  logic            delta_active;
  logic            filtered;
  logic            accept;
  logic            deq;
  logic            can_enq;
  logic            enq;
  logic            drop;
  logic [EW-1:0]   head_entry;

  // Per-slot comparison against the shadow copy
  genvar gi;
  generate
    for (gi = 0; gi < NCSR; gi++) begin : g_diff
      assign diff_mask[gi] = (commit_csrs[gi*XLEN +: XLEN] != shadow_csrs_reg[gi*XLEN +: XLEN]);
    end
  endgenerate

  // Commit classification: filter, enqueue or drop
  always_comb begin
    delta_active = mode && shadow_valid_reg;
    commit_mask  = delta_active ? diff_mask : {NCSR{1'b1}};
    filtered     = delta_active && (diff_mask == '0) && (commit_priv == shadow_priv_reg);
    accept       = commit_valid && !filtered;
    deq          = out_valid && out_ready;
    // A full FIFO still takes a commit if the head leaves on the same edge
    can_enq      = (count_reg != DEPTH_C) || deq;
    enq          = accept && can_enq;
    drop         = accept && !can_enq;
  end

  // Occupancy update for the enqueue/dequeue combination
  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Control state: pointers, occupancy, sequence, shadow valid, drop tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      seq_reg          <= '0;
      shadow_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      drop_cnt_reg     <= '0;
    end else begin
      count_reg <= count_next;
      if (enq) begin
        wr_ptr_reg       <= wr_ptr_reg + 1'b1;
        seq_reg          <= seq_reg + 16'd1;
        shadow_valid_reg <= 1'b1;
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Payload storage and shadow data; no reset needed, qualified by valid bits
  always_ff @(posedge clock) begin
    if (reset_n && enq) begin
      entry_mem[wr_ptr_reg] <= {commit_priv, commit_csrs, commit_mask, seq_reg};
      shadow_priv_reg       <= commit_priv;
      shadow_csrs_reg       <= commit_csrs;
    end
  end

  assign head_entry = entry_mem[rd_ptr_reg];

  assign out_valid = (count_reg != '0);
  assign out_priv  = head_entry[EW-1 -: 2];
  assign out_csrs  = head_entry[NCSR+16 +: VW];
  assign out_mask  = head_entry[16 +: NCSR];
  assign out_seq   = head_entry[15:0];
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_csr_diff_buffer.sv
// tb_csr_diff_buffer
// Directed stimulus with a scoreboard: each scenario pushes the entries it
// expects the FIFO to deliver; a negedge monitor pops and compares every
// handshake the DUT completes. Status outputs are checked inline.
module tb_csr_diff_buffer;

  localparam int NCSR  = 17;
  localparam int XLEN  = 76;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [NCSR*XLEN-1:0] vec_t;

  typedef struct {
    logic [1:0]      priv;
    vec_t            csrs;
    logic [NCSR-1:0] mask;
    logic [15:0]     seq;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            mode;
  logic            commit_valid;
  logic [1:0]      commit_priv;
  vec_t            commit_csrs;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_priv;
  vec_t            out_csrs;
  logic [NCSR-1:0] out_mask;
  logic [15:0]     out_seq;
  logic            overflow;
  logic [15:0]     drop_cnt;
  logic [CW-1:0]   count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  csr_diff_buffer #(.NCSR(NCSR), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .commit_valid(commit_valid), .commit_priv(commit_priv), .commit_csrs(commit_csrs),
    .out_valid(out_valid), .out_ready(out_ready), .out_priv(out_priv),
    .out_csrs(out_csrs), .out_mask(out_mask), .out_seq(out_seq),
    .overflow(overflow), .drop_cnt(drop_cnt), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Every slot differs between seeds; slot index keeps slots distinct
  function automatic vec_t mk(input int seed);
    vec_t v;
    for (int i = 0; i < NCSR; i++) begin
      v[i*XLEN +: XLEN] = (XLEN'(seed) << 40) | XLEN'(i + 1);
    end
    return v;
  endfunction

  function automatic vec_t setslot(input vec_t v, input int k, input int val);
    vec_t r;
    r = v;
    r[k*XLEN +: XLEN] = XLEN'(val) << 8;
    return r;
  endfunction

  task automatic push_exp(input logic [1:0] p, input vec_t v, input logic [NCSR-1:0] m, input logic [15:0] s);
    exp_t e;
    e.priv = p; e.csrs = v; e.mask = m; e.seq = s;
    sb.push_back(e);
  endtask

  // One-cycle commit strobe; called and returns at posedge+1
  task automatic commit(input logic [1:0] p, input vec_t v, input logic m);
    commit_valid = 1'b1;
    commit_priv  = p;
    commit_csrs  = v;
    mode         = m;
    @(posedge clock); #1;
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && count != 0; i++) begin
      @(posedge clock); #1;
    end
    chk("drain_count", 32'(count), 0);
    out_ready = 1'b0;
  endtask

  // Monitor: compare each completed handshake with the scoreboard head
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry: got seq %0h expected no entry", out_seq);
      end else begin
        exp_t e;
        int bad;
        e = sb.pop_front();
        bad = -1;
        for (int i = 0; i < NCSR; i++) begin
          if (bad < 0 && out_csrs[i*XLEN +: XLEN] !== e.csrs[i*XLEN +: XLEN]) bad = i;
        end
        $display("txn  seq=%0h priv=%0h mask=%05h", out_seq, out_priv, out_mask);
        chk("out_seq", 32'(out_seq), 32'(e.seq));
        chk("out_priv", 32'(out_priv), 32'(e.priv));
        chk("out_mask", 32'(out_mask), 32'(e.mask));
        chk("out_csrs_first_bad_slot", bad, -1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a, a3, d0, d1, d2, d3, d4, d5, e;
    localparam logic [NCSR-1:0] ALL = {NCSR{1'b1}};

    reset_n = 1'b0; mode = 1'b0; commit_valid = 1'b0; commit_priv = 2'd0;
    commit_csrs = '0; out_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    reset_n = 1'b1;

    // Full-snapshot mode, consumer always ready
    out_ready = 1'b1;
    push_exp(2'd3, mk(1), ALL, 16'd0);
    commit(2'd3, mk(1), 1'b0);
    chk("snap_valid0", 32'(out_valid), 1);
    push_exp(2'd3, mk(2), ALL, 16'd1);
    commit(2'd3, mk(2), 1'b0);
    chk("snap_count1", 32'(count), 1);
    push_exp(2'd3, mk(3), ALL, 16'd2);
    commit(2'd3, mk(3), 1'b0);
    chk("snap_count2", 32'(count), 1);
    @(posedge clock); #1;
    chk("snap_empty", 32'(count), 0);
    out_ready = 1'b0;

    // Delta mode: first full, one-slot change, identical repeat filtered
    do_reset();
    a  = mk(5);
    a3 = setslot(a, 3, 32'h777);
    push_exp(2'd3, a, ALL, 16'd0);
    commit(2'd3, a, 1'b1);
    push_exp(2'd3, a3, 17'h00008, 16'd1);
    commit(2'd3, a3, 1'b1);
    commit(2'd3, a3, 1'b1);
    chk("delta_count", 32'(count), 2);
    drain();

    // Privilege-only change is still enqueued, with an empty mask
    push_exp(2'd1, a3, 17'h00000, 16'd2);
    commit(2'd1, a3, 1'b1);
    drain();

    // Overflow: six commits into a stalled FIFO
    do_reset();
    d0 = mk(10);
    d1 = setslot(d0, 1, 32'h101);
    d2 = setslot(d1, 2, 32'h202);
    d3 = setslot(d2, 3, 32'h303);
    d4 = setslot(d3, 4, 32'h404);
    d5 = setslot(d4, 5, 32'h505);
    push_exp(2'd0, d0, ALL, 16'd0);
    commit(2'd0, d0, 1'b1);
    push_exp(2'd0, d1, 17'h00002, 16'd1);
    commit(2'd0, d1, 1'b1);
    push_exp(2'd0, d2, 17'h00004, 16'd2);
    commit(2'd0, d2, 1'b1);
    push_exp(2'd0, d3, 17'h00008, 16'd3);
    commit(2'd0, d3, 1'b1);
    commit(2'd0, d4, 1'b1);
    commit(2'd0, d5, 1'b1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 2);
    drain();
    e = setslot(d5, 7, 32'h999);
    push_exp(2'd0, e, 17'h000B0, 16'd4);
    commit(2'd0, e, 1'b1);
    drain();
    chk("ovf_sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous dequeue accepts the commit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_exp(2'd2, mk(20 + k), ALL, 16'(k));
      commit(2'd2, mk(20 + k), 1'b0);
    end
    chk("full_count", 32'(count), 4);
    out_ready = 1'b1;
    push_exp(2'd2, mk(30), ALL, 16'd4);
    commit(2'd2, mk(30), 1'b0);
    out_ready = 1'b0;
    chk("full_swap_count", 32'(count), 4);
    chk("full_swap_drop", 32'(drop_cnt), 0);
    chk("full_swap_ovf", 32'(overflow), 0);
    drain();

    // Reset while partly full and overflowed
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push_exp(2'd0, mk(40 + k), ALL, 16'(k));
      commit(2'd0, mk(40 + k), 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_ovf", 32'(overflow), 1);
    reset_n = 1'b0;
    commit_valid = 1'b1; commit_priv = 2'd1; commit_csrs = mk(50); mode = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    commit_valid = 1'b0;
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_ovf", 32'(overflow), 0);
    chk("post_rst_drop", 32'(drop_cnt), 0);
    push_exp(2'd1, mk(50), ALL, 16'd0);
    commit(2'd1, mk(50), 1'b1);
    drain();

    @(posedge clock); #1;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
